// File: rtl/aes_pkg.sv
// Shared AES-128 constants and GF(2^8) helpers, used by both the encryption and decryption tops.
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT} state_e;

    // Byte-indexed lookup tables: SBOX[8'h00] is the first entry.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] state_out
);

    always_comb begin : p_round
        logic [127:0] ark;
        logic [127:0] mixed;
        logic [7:0]   a0, a1, a2, a3;
        ark   = '0;
        mixed = '0;
        a0    = '0;
        a1    = '0;
        a2    = '0;
        a3    = '0;
        // Byte (r,c) sits at index 4c+r; row r rotates right by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ark[127-8*(4*c+r) -: 8] = INV_SBOX[state_in[127-8*(4*((c-r+4)%4)+r) -: 8]];
            end
        end
        ark = ark ^ round_key;
        for (int c = 0; c < 4; c++) begin
            a0 = ark[127-32*c -: 8];
            a1 = ark[119-32*c -: 8];
            a2 = ark[111-32*c -: 8];
            a3 = ark[103-32*c -: 8];
            mixed[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            mixed[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            mixed[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            mixed[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        state_out = last ? ark : mixed;
    end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption: forward key expansion (10 cycles) then ten inverse rounds (10 cycles).
module aes_inv_cipher
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key,
    output logic         out_valid,
    output logic [127:0] data_out
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    state_e       state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] st_q, st_d;
    logic [127:0] dout_q, dout_d;
    logic         ovld_q, ovld_d;
    logic [127:0] rk_q [0:NR];
    logic [127:0] rk_d [0:NR];

    logic [127:0] rk_prev, rk_new, round_out;
    logic [31:0]  temp, w0, w1, w2, w3;

    // Next round key from the previous one, using rcon for the round being built.
    always_comb begin
        rk_prev = (rnd_q == 4'd0) ? rk_q[0] : rk_q[rnd_q - 4'd1];
        temp    = sub_word(rot_word(rk_prev[31:0])) ^ {RCON[rnd_q], 24'h000000};
        w0      = rk_prev[127:96] ^ temp;
        w1      = rk_prev[95:64] ^ w0;
        w2      = rk_prev[63:32] ^ w1;
        w3      = rk_prev[31:0] ^ w2;
        rk_new  = {w0, w1, w2, w3};
    end

    aes_inv_round u_round (
        .state_in  (st_q),
        .round_key (rk_q[rnd_q]),
        .last      (rnd_q == 4'd0),
        .state_out (round_out)
    );

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        ct_d    = ct_q;
        st_d    = st_q;
        dout_d  = dout_q;
        ovld_d  = 1'b0;
        for (int i = 0; i <= NR; i++) rk_d[i] = rk_q[i];
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ct_d    = data_in;
                    rk_d[0] = key;
                    rnd_d   = 4'd1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                rk_d[rnd_q] = rk_new;
                if (rnd_q == LAST_RND) begin
                    st_d    = ct_q ^ rk_new;
                    rnd_d   = LAST_RND - 4'd1;
                    state_d = DECRYPT;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            DECRYPT: begin
                if (rnd_q == 4'd0) begin
                    dout_d  = round_out;
                    ovld_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    st_d  = round_out;
                    rnd_d = rnd_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
            ct_q    <= '0;
            st_q    <= '0;
            dout_q  <= '0;
            ovld_q  <= 1'b0;
            for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            ct_q    <= ct_d;
            st_q    <= st_d;
            dout_q  <= dout_d;
            ovld_q  <= ovld_d;
            for (int i = 0; i <= NR; i++) rk_q[i] <= rk_d[i];
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = ovld_q;
    assign data_out  = dout_q;

endmodule

// File: doc/aes_inv_cipher.md
# aes_inv_cipher

Iterative AES-128 decryption core, the inverse of the pipelined AES-128 encryption top: it recovers plaintext from a 128-bit ciphertext and the original 128-bit cipher key. The core expands the key schedule forward on-chip, then applies the ten inverse rounds in reverse key order, one round per clock. It sits on the receive side of the crypto datapath behind a valid/ready input handshake and produces a one-cycle result strobe.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10).
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  ciphertext/key pair presented
- in_ready  output  1  core idle and able to accept
- data_in  input  128  ciphertext; byte 0 = bits [127:120], FIPS-197 column-major state
- key  input  128  cipher key (same key used for encryption), same byte order
- out_valid  output  1  one-cycle strobe, data_out holds a new plaintext
- data_out  output  128  plaintext, held until the next result or reset

## Operation
- States: IDLE, EXPAND, DECRYPT.
- IDLE: in_ready=1. On in_valid, latch data_in into ct_reg and key into rk[0]. Set rnd=1 and go to EXPAND.
- EXPAND: one cycle per round key, rk[rnd] = f(rk[rnd-1], rcon[rnd]). This uses the standard RotWord, SubWord and Rcon recurrence. rcon runs 01,02,04,08,10,20,40,80,1b,36.
  - On rnd=10, also load state = ct_reg ^ rk[10] (initial AddRoundKey) using the combinationally computed rk[10].
  - Then set rnd=9 and go to DECRYPT.
- DECRYPT, rnd 9..1: state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[rnd]). Decrement rnd.
- DECRYPT, rnd 0: data_out = InvSubBytes(InvShiftRows(state)) ^ rk[0]. Pulse out_valid and return to IDLE.
- Key storage: 11 × 128-bit register array. It is fully rewritten on every accepted transaction; there is no key caching.
- GF(2^8) arithmetic uses the polynomial x^8+x^4+x^3+x+1. InvMixColumns multiplies each column by {0e,0b,0d,09}.
- in_valid outside IDLE is ignored. in_ready=0 in EXPAND and DECRYPT, and data_in/key are not sampled there.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, data_out=0, rnd=0. The state register and the rk array are cleared to 0.
- Let accept edge = cycle T (in_valid & in_ready). Then:
  - EXPAND occupies T+1..T+10.
  - DECRYPT occupies T+11..T+20.
  - out_valid=1 and the new data_out are visible in T+21, for exactly one cycle.
- Latency is 21 cycles. in_ready is high again in T+21, so a back-to-back accept at T+21 gives 21-cycle throughput.
- An accept in the same cycle as out_valid is legal. It latches the new inputs; data_out keeps the old result until the next completion.
- Reset asserted in any state has effect on the next edge:
  - The transaction is aborted and the core returns to IDLE.
  - out_valid=0 and data_out=0.
  - No result is ever produced for the aborted transaction.
- Reset and in_valid in the same cycle: reset wins, nothing is accepted.
- There is no output backpressure. The consumer must capture data_out on out_valid or before the next completion.

## Structure
- Shared package aes_pkg holds:
  - sbox[256] and inv_sbox[256] constant tables, rcon[1..10].
  - Functions xtime, gmul, sub_word, rot_word.
  - Localparams NR=10 and the state enum {IDLE, EXPAND, DECRYPT}.
- The encryption top reuses the same package.
- One combinational sub-module, aes_inv_round, maps (state, round_key, last) to next state. It performs InvShiftRows, then InvSubBytes, then AddRoundKey, then InvMixColumns only when !last. It is instantiated once.
- The key-expansion step and the FSM live in aes_inv_cipher.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data_in 69c4e0d86a7b0430d8cdb78070b4c55a -> out_valid at T+21 with data_out 00112233445566778899aabbccddeeff.
- Second pair: key 0f1571c947d9e8590cb7add6af7f6798, data_in ff0b844a0853bf7c6934ab4364148fb9 -> data_out 0123456789abcdeffedcba9876543210.
  - Then hold in_valid high alternating with C.1, accepting on each in_ready.
  - Required: accepts exactly 21 cycles apart, correct alternating plaintexts, out_valid never high for two consecutive cycles.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, data_in 3925841d02dc09fbdc118597196a0b32 -> data_out 3243f6a8885a308d313198a2e0370734.
  - During the run, toggle data_in/key while busy -> result unaffected.
- Reset check: reset high at T+15 mid-DECRYPT -> next cycle in_ready=1, out_valid=0, data_out=0, no strobe at T+21.
  - A subsequent C.1 transaction must still decrypt correctly.
- Initial reset: reset asserted together with in_valid -> no accept, outputs stay at reset values.
  - After release, an accept occurs on the first cycle in_valid is high.
